rs232_to_axis: RTL and testbench
================================

// Module: rs232_to_axis
// PURPOSE
//   RS232 receiver: samples the serial RXD line, assembles 8N1 frames (LSB first) and delivers
//   bytes as an AXI-style byte stream through a small FIFO. Drives RTSn hardware flow control
//   with enough FIFO headroom to absorb the one extra byte a transmitter may still start after
//   RTSn rises. Mirror of axis_to_rs232 on the far side of the wire; its txd/ctsn pins connect
//   to this block's rxd_pin/rtsn_pin.
// PARAMETERS
//   CLOCK_FREQ  133000000  clock frequency in Hz (real)
//   BAUD_RATE   115200     line rate in bit/s (real)
//   FIFO_DEPTH  4          receive FIFO entries; power of two, >= 4
// PORTS
//   clock     in   1  system clock, all logic on rising edge
//   reset     in   1  synchronous, active-high reset
//   odata     out  8  received byte (head of FIFO)
//   ovalid    out  1  odata holds a valid byte
//   oready    in   1  consumer accepts odata this cycle when ovalid && oready
//   rxd_pin   in   1  serial input, idle high; asynchronous to clock
//   rtsn_pin  out  1  0 = ready to receive, 1 = transmitter must pause
//   frame_err out  1  one-cycle pulse: stop bit sampled as 0, byte discarded
//   overrun   out  1  one-cycle pulse: good byte arrived with FIFO full, byte discarded
// BEHAVIOUR
// - Reset: odata=0, ovalid=0, rtsn_pin=1, frame_err=0, overrun=0, FIFO empty, FSM=IDLE,
//   sync flops=1. Reset mid-frame abandons the frame; no partial byte is ever written.
// - BAUD_COUNT = round(CLOCK_FREQ/BAUD_RATE), elaboration error if < 4; HALF = BAUD_COUNT/2 (floor).
// - rxd_pin passes two flops (reset 1) before use -> rxd_s; 2-cycle input latency.
// - FSM: IDLE, START, DATA, STOP, BREAK.
//   IDLE : rxd_s==0 -> START, load counter for HALF cycles.
//   START: at counter expiry sample rxd_s; 0 -> DATA (counter BAUD_COUNT, bit index 0);
//          1 -> IDLE (glitch rejected, nothing reported).
//   DATA : every BAUD_COUNT cycles sample rxd_s into bit[index], LSB first; after bit 7 -> STOP.
//   STOP : after BAUD_COUNT cycles sample rxd_s. 1 -> write byte to FIFO, -> IDLE (IDLE is
//          re-entered mid stop bit, so a start edge one baud later is caught).
//          0 -> frame_err pulse, byte discarded, -> BREAK.
//   BREAK: wait for rxd_s==1 -> IDLE (prevents a long break from re-triggering frames).
// - FIFO write occurs in the stop-sample cycle; ovalid rises the following cycle if FIFO was empty.
// - Write when full: accepted iff a pop happens the same cycle (count unchanged); otherwise
//   byte dropped, overrun pulses for exactly that cycle, FIFO contents untouched.
// - Output handshake: pop on ovalid && oready. odata/ovalid stable while ovalid && !oready.
//   ovalid = FIFO non-empty (registered). Back-to-back pops at one per clock supported.
// - Flow control, registered: rtsn_pin <= (count >= FIFO_DEPTH-2) in every non-reset cycle.
//   Deasserts (0) once count drops below threshold. Leaves >= 2 free slots when raised.
// - Counters/pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// - frame_err and overrun are never high in the same cycle, and never high in reset.
// TESTING (CLOCK_FREQ=1e6, BAUD_RATE=1e5 -> BAUD_COUNT=10, FIFO_DEPTH=4, oready=1 unless noted)
// 1. Send 0x55 then 0xA3 back-to-back, 1 stop bit each -> ovalid pulses, odata 0x55 then 0xA3, no errors.
// 2. rxd_pin low for 3 cycles then high -> no ovalid, no frame_err, FSM back to IDLE.
// 3. Send 0x3C with stop bit 0, line then held low 30 cycles -> one frame_err pulse, no byte;
//    next valid 0x81 after line returns high received correctly.
// 4. oready=0, send 0x01..0x05 -> rtsn_pin=1 from cycle after 2nd byte written; 5th byte gives one
//    overrun pulse; then oready=1 pops 0x01,0x02,0x03,0x04 in order, rtsn_pin returns 0.
// 5. oready=0, FIFO full, assert oready exactly in stop-sample cycle of next byte -> no overrun, count stays 4.
// 6. Assert reset in middle of DATA of 0x77 -> outputs at reset values, no byte delivered; next 0x12 received.

Source files
------------

// File: rtl/rs232_to_axis.sv
`timescale 1ns/1ps
// ============================================================================
// rs232_to_axis
// ----------------------------------------------------------------------------
// Purpose:
//   Receive side of an RS232 link. The block samples the asynchronous RXD line
//   and assembles 8N1 frames, least significant bit first. Each completed byte
//   is handed on as an AXI-style byte stream through a small FIFO. RTSn flow
//   control is raised early enough to keep two free FIFO slots, so the block
//   can still absorb the extra byte that a transmitter may begin after RTSn
//   goes high.
//
// Ports:
//   clock      in   1  system clock; all logic runs on the rising edge
//   reset      in   1  synchronous, active-high reset
//   odata      out  8  byte at the head of the FIFO
//   ovalid     out  1  odata holds a valid byte
//   oready     in   1  the consumer takes odata when ovalid && oready
//   rxd_pin    in   1  serial input; idles high; asynchronous to clock
//   rtsn_pin   out  1  0 = ready to receive, 1 = transmitter must pause
//   frame_err  out  1  one-cycle pulse; the stop bit was sampled low and the
//                      byte was discarded
//   overrun    out  1  one-cycle pulse; a good byte arrived while the FIFO was
//                      full, and the byte was discarded
//
// Receiver FSM:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | line idle; waiting for a falling edge on rxd_s
//   S_START | counting half a bit, then confirming the start bit mid-cell
//   S_DATA  | sampling 8 data bits, one per bit time, mid-cell
//   S_STOP  | sampling the stop bit mid-cell; push the byte or flag an error
//   S_BREAK | line held low after a framing error; waiting for it to go high
// ============================================================================
module rs232_to_axis #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready,
    input  logic       rxd_pin,
    output logic       rtsn_pin,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BAUD_COUNT = $rtoi((CLOCK_FREQ / BAUD_RATE) + 0.5);
    localparam int HALF       = BAUD_COUNT / 2;
    localparam int CW         = $clog2(BAUD_COUNT);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int NW         = AW + 1;

    if (BAUD_COUNT < 4) begin : g_bad_baud
        $error("rs232_to_axis: CLOCK_FREQ/BAUD_RATE must round to at least 4");
    end
    if ((FIFO_DEPTH < 4) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
        $error("rs232_to_axis: FIFO_DEPTH must be a power of two and at least 4");
    end

    // ------------------------------------------------------------------
    // Input synchroniser. The flops reset to 1, which reads as an idle line.
    // ------------------------------------------------------------------
    logic sync1;
    logic rxd_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd_pin;
            rxd_s <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [7:0]    shreg;
    logic [7:0]    shreg_next;
    logic          expire;
    logic          byte_done;

    assign expire = (cnt == '0);

    // State register, together with the bit timer and the shift register.
    // When reset arrives mid-frame, the shifter is cleared and no byte is
    // pushed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
        end
    end

    // Next-state logic. The timer is a down-counter that parks at zero. A
    // reload value of N-1 makes the sample land N cycles after the load.
    always_comb begin
        state_next = state;
        cnt_next   = expire ? cnt : cnt - CW'(1);
        idx_next   = idx;
        shreg_next = shreg;
        case (state)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_next = S_START;
                    cnt_next   = CW'(HALF - 1);
                end
            end
            S_START: begin
                if (expire) begin
                    if (!rxd_s) begin
                        state_next = S_DATA;
                        cnt_next   = CW'(BAUD_COUNT - 1);
                        idx_next   = 3'd0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shreg_next = {rxd_s, shreg[7:1]};
                    cnt_next   = CW'(BAUD_COUNT - 1);
                    if (idx == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // The FSM returns to IDLE half way through the stop bit. This
                // lets it catch a start edge that follows straight after.
                if (expire) begin
                    state_next = rxd_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxd_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs. These are decoded only in the cycle that samples the stop
    // bit. They are gated by reset, so no pulse can appear while reset is held.
    always_comb begin
        byte_done = 1'b0;
        frame_err = 1'b0;
        if (!reset && (state == S_STOP) && expire) begin
            byte_done = rxd_s;
            frame_err = !rxd_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic [NW-1:0] count_next;
    logic          full;
    logic          pop;
    logic          push;

    assign full = (count == NW'(FIFO_DEPTH));
    assign pop  = ovalid && oready;
    // When the FIFO is full, a byte is still accepted if a pop frees a slot
    // on the same edge.
    assign push = byte_done && (!full || pop);

    always_comb begin
        overrun = byte_done && full && !pop;
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + NW'(1);
        end else if (pop && !push) begin
            count_next = count - NW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovalid   <= 1'b0;
            rtsn_pin <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            ovalid   <= (count_next != '0);
            rtsn_pin <= (count >= NW'(FIFO_DEPTH - 2));
        end
    end

    // The head entry comes straight out of the register file. It stays
    // stable while the consumer stalls.
    assign odata = mem[rd_ptr];

endmodule

// File: tb/tb_rs232_to_axis.sv
`timescale 1ns/1ps
module tb_rs232_to_axis;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       oready = 1'b1;
    logic       rxd_pin = 1'b1;
    logic [7:0] odata;
    logic       ovalid;
    logic       rtsn_pin;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_frame = 0;
    int         n_over = 0;
    logic [7:0] exp_q[$];

    rs232_to_axis #(
        .CLOCK_FREQ(1000000.0),
        .BAUD_RATE (100000.0),
        .FIFO_DEPTH(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .odata    (odata),
        .ovalid   (ovalid),
        .oready   (oready),
        .rxd_pin  (rxd_pin),
        .rtsn_pin (rtsn_pin),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and scoreboard. A pop happens on the next rising edge whenever
    // ovalid && oready holds at the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_err) n_frame++;
            if (overrun) n_over++;
            if (frame_err || overrun) check("err_exclusive", {31'd0, frame_err & overrun}, 32'd0);
            if (ovalid && oready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h expected none", odata);
                end else begin
                    check("odata", {24'd0, odata}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Each bit is 10 clocks. The start bit is driven just after edge k, and
    // the stop bit is sampled in the cycle after edge k+97.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic pop_at_stop);
        @(posedge clock);
        #1 rxd_pin = 1'b0;
        repeat (10) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #1 rxd_pin = b[i];
            repeat (10) @(posedge clock);
        end
        #1 rxd_pin = stop;
        repeat (7) @(posedge clock);
        if (pop_at_stop) #1 oready = 1'b1;
        @(posedge clock);
        if (pop_at_stop) #1 oready = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clock);
            c++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ovalid"}, {31'd0, ovalid}, 32'd0);
        check({tag, "_odata"}, {24'd0, odata}, 32'd0);
        check({tag, "_rtsn"}, {31'd0, rtsn_pin}, 32'd1);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b77;
        b77 = 8'h77;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        check("rtsn_idle", {31'd0, rtsn_pin}, 32'd0);

        // Test 1: two frames back to back
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, 1'b0);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1, 1'b0);
        wait_drain("t1_drain");
        check("t1_frame_err", n_frame, 32'd0);
        check("t1_overrun", n_over, 32'd0);

        // Test 2: a 3-cycle low glitch is rejected
        @(posedge clock);
        #1 rxd_pin = 1'b0;
        repeat (3) @(posedge clock);
        #1 rxd_pin = 1'b1;
        repeat (30) @(negedge clock);
        check("t2_no_valid", {31'd0, ovalid}, 32'd0);
        check("t2_frame_err", n_frame, 32'd0);

        // Test 3: stop bit 0, then line held low, then a good byte
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (20) @(posedge clock);
        #1 rxd_pin = 1'b1;
        repeat (20) @(negedge clock);
        check("t3_frame_err", n_frame, 32'd1);
        check("t3_no_valid", {31'd0, ovalid}, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 1'b0);
        wait_drain("t3_drain");
        check("t3_frame_err_once", n_frame, 32'd1);

        // Test 4: stalled consumer, flow control, and overrun
        @(posedge clock);
        #1 oready = 1'b0;
        exp_q.push_back(8'h01);
        send_byte(8'h01, 1'b1, 1'b0);
        @(negedge clock);
        check("t4_rtsn_after_1", {31'd0, rtsn_pin}, 32'd0);
        check("t4_valid_after_1", {31'd0, ovalid}, 32'd1);
        exp_q.push_back(8'h02);
        send_byte(8'h02, 1'b1, 1'b0);
        @(negedge clock);
        check("t4_rtsn_after_2", {31'd0, rtsn_pin}, 32'd1);
        exp_q.push_back(8'h03);
        send_byte(8'h03, 1'b1, 1'b0);
        exp_q.push_back(8'h04);
        send_byte(8'h04, 1'b1, 1'b0);
        check("t4_no_overrun_yet", n_over, 32'd0);
        send_byte(8'h05, 1'b1, 1'b0);
        @(negedge clock);
        check("t4_overrun", n_over, 32'd1);
        check("t4_rtsn_full", {31'd0, rtsn_pin}, 32'd1);
        check("t4_head_stable", {24'd0, odata}, 32'h01);
        @(posedge clock);
        #1 oready = 1'b1;
        wait_drain("t4_drain");
        repeat (5) @(negedge clock);
        check("t4_rtsn_release", {31'd0, rtsn_pin}, 32'd0);
        check("t4_empty", {31'd0, ovalid}, 32'd0);

        // Test 5: full FIFO, with a pop in the same cycle as the stop sample
        @(posedge clock);
        #1 oready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            send_byte(8'hA0 + 8'(i), 1'b1, 1'b0);
        end
        exp_q.push_back(8'hA4);
        send_byte(8'hA4, 1'b1, 1'b1);
        @(negedge clock);
        check("t5_no_overrun", n_over, 32'd1);
        check("t5_rtsn_full", {31'd0, rtsn_pin}, 32'd1);
        check("t5_head", {24'd0, odata}, 32'hA1);
        check("t5_queue_left", exp_q.size(), 32'd4);
        @(posedge clock);
        #1 oready = 1'b1;
        wait_drain("t5_drain");

        // Test 6: reset in the middle of the data bits
        @(posedge clock);
        #1 rxd_pin = 1'b0;
        repeat (10) @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            #1 rxd_pin = b77[i];
            repeat (10) @(posedge clock);
        end
        #1 reset = 1'b1;
        rxd_pin = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_vals("t6_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (120) @(negedge clock);
        check("t6_no_byte", {31'd0, ovalid}, 32'd0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        wait_drain("t6_drain");

        repeat (5) @(negedge clock);
        check("final_frame_err", n_frame, 32'd1);
        check("final_overrun", n_over, 32'd1);
        check("final_queue", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
